// File: rtl/turbo_frame_ctrl_pkg.sv
// Shared types and constants for the turbo-encoder frame sequencer.
// No logic of its own; imported by the interface, top and serializer.
// No flow control here.
package turbo_frame_ctrl_pkg;

    // Codeword width coming back from the encoder and the byte width on both streams.
    localparam int CW_W     = 24;
    localparam int BYTE_W   = 8;
    // Bytes per codeword on the transmit stream.
    localparam int TX_BYTES = CW_W / BYTE_W;

    // Controller sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_WAIT = 3'd2,
        ST_SEND = 3'd3,
        ST_NEXT = 3'd4
    } state_t;

    // Interleaver select encodings driven to the encoder.
    typedef enum logic [1:0] {
        SEL_ILV0 = 2'd0,
        SEL_ILV1 = 2'd1,
        SEL_ILV2 = 2'd2,
        SEL_ILV3 = 2'd3
    } ilv_sel_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Most significant byte of a codeword: the next byte to put on the wire.
    function automatic logic [BYTE_W-1:0] cw_top_byte(input logic [CW_W-1:0] cw);
        return cw[CW_W-1 -: BYTE_W];
    endfunction

endpackage

// File: rtl/turbo_frame_ctrl_if.sv
// Bundle of the input stream, encoder side-band and transmit stream.
// Pure wiring, no latency.
// Carries both valid/ready pairs; no buffering.
interface turbo_frame_ctrl_if;
    import turbo_frame_ctrl_pkg::*;

    // upstream byte stream and per-frame configuration
    logic [1:0]        cfg_sel;
    logic              in_valid;
    logic [BYTE_W-1:0] in_data;
    logic              in_ready;

    // encoder side
    logic              enc_rst;
    logic [1:0]        enc_sel;
    logic [BYTE_W-1:0] enc_data;
    logic [CW_W-1:0]   enc_out;

    // transmit stream toward the UART
    logic              tx_valid;
    logic [BYTE_W-1:0] tx_data;
    logic              tx_ready;

    // status
    logic              busy;
    logic              frame_done;

    // controller side
    modport slave (
        input  cfg_sel, in_valid, in_data, enc_out, tx_ready,
        output in_ready, enc_rst, enc_sel, enc_data, tx_valid, tx_data, busy, frame_done
    );

    // environment side (upstream source, encoder model, UART sink)
    modport master (
        output cfg_sel, in_valid, in_data, enc_out, tx_ready,
        input  in_ready, enc_rst, enc_sel, enc_data, tx_valid, tx_data, busy, frame_done
    );

endinterface

// File: rtl/turbo_frame_ctrl_cw_serializer.sv
// Captures a 24-bit codeword and emits it MSB byte first as 3 transfers.
// tx_valid rises the cycle after load; one byte per accepted transfer.
// Holds tx_data/tx_valid stable while tx_ready is low; done pulses on the 3rd transfer.
module turbo_frame_ctrl_cw_serializer
    import turbo_frame_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [CW_W-1:0]   codeword,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [BYTE_W-1:0] tx_data,
    output logic              done
);

    localparam int IDX_W = cnt_width(TX_BYTES);

    logic [CW_W-1:0]  shreg;
    logic [IDX_W-1:0] idx;
    logic             fire;
    logic             last;

    assign fire    = tx_valid & tx_ready;
    assign last    = (idx == IDX_W'(TX_BYTES - 1));
    assign done    = fire & last;
    assign tx_data = cw_top_byte(shreg);

    // Load on request, otherwise shift one byte out per completed transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg    <= '0;
            idx      <= '0;
            tx_valid <= 1'b0;
        end else if (load) begin
            shreg    <= codeword;
            idx      <= '0;
            tx_valid <= 1'b1;
        end else if (fire) begin
            shreg <= {shreg[CW_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
            if (last) begin
                idx      <= '0;
                tx_valid <= 1'b0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/turbo_frame_ctrl.sv
// Frame sequencer: accepts bytes, clears/drives the turbo encoder, serialises codewords.
// First byte of a frame: first tx byte 2+ENC_LATENCY cycles after accept; later bytes 1+ENC_LATENCY.
// in_ready only in IDLE/NEXT; transmit side stalls on tx_ready without losing data.
module turbo_frame_ctrl
    import turbo_frame_ctrl_pkg::*;
#(
    parameter int ENC_LATENCY = 4,  // >= 1
    parameter int FRAME_LEN   = 4   // >= 1
)(
    input  logic               clk,
    input  logic               reset,
    turbo_frame_ctrl_if.slave  bus
);

    localparam int WAIT_W = cnt_width(ENC_LATENCY);
    localparam int FRM_W  = cnt_width(FRAME_LEN);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(ENC_LATENCY - 1);
    localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(FRAME_LEN - 1);

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [FRM_W-1:0]  frame_cnt;
    ilv_sel_t          sel_q;
    logic [BYTE_W-1:0] data_q;
    logic              frame_done_q;

    logic              in_ready_c;
    logic              enc_rst_c;
    logic              busy_c;
    logic              accept;
    logic              last_byte;
    logic              wait_over;
    logic              ser_load;
    logic              ser_done;
    logic              ser_valid;
    logic [BYTE_W-1:0] ser_data;

    assign accept    = bus.in_valid & in_ready_c;
    assign last_byte = (frame_cnt == FRM_LAST);
    assign wait_over = (state == ST_WAIT) && (wait_cnt == '0);
    // The codeword is sampled exactly once per byte, at the end of the hold window.
    assign ser_load  = wait_over;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)    state_nxt = ST_CLR;
            ST_CLR:                 state_nxt = ST_WAIT;
            ST_WAIT: if (wait_over) state_nxt = ST_SEND;
            ST_SEND: if (ser_done)  state_nxt = last_byte ? ST_IDLE : ST_NEXT;
            ST_NEXT: if (accept)    state_nxt = ST_WAIT;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs; in_ready is masked by reset because IDLE is the reset state.
    always_comb begin
        in_ready_c = 1'b0;
        enc_rst_c  = 1'b0;
        busy_c     = 1'b0;
        case (state)
            ST_IDLE: in_ready_c = ~reset;
            ST_CLR: begin
                enc_rst_c = 1'b1;
                busy_c    = 1'b1;
            end
            ST_WAIT: busy_c = 1'b1;
            ST_SEND: busy_c = 1'b1;
            ST_NEXT: begin
                in_ready_c = ~reset;
                busy_c     = 1'b1;
            end
            default: begin
                in_ready_c = 1'b0;
                enc_rst_c  = 1'b0;
                busy_c     = 1'b0;
            end
        endcase
    end

    // Datapath: per-frame select, held encoder byte, hold-window and frame-position counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q        <= SEL_ILV0;
            data_q       <= '0;
            wait_cnt     <= '0;
            frame_cnt    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            // Registered so the pulse lands in the first IDLE cycle.
            frame_done_q <= (state == ST_SEND) && ser_done && last_byte;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        sel_q     <= ilv_sel_t'(bus.cfg_sel);
                        data_q    <= bus.in_data;
                        frame_cnt <= '0;
                    end
                end
                ST_CLR: begin
                    wait_cnt <= WAIT_LOAD;
                end
                ST_WAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_SEND: begin
                    if (ser_done && !last_byte) begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
                ST_NEXT: begin
                    // No encoder clear here: encoder state carries across bytes of a frame.
                    if (accept) begin
                        data_q   <= bus.in_data;
                        wait_cnt <= WAIT_LOAD;
                    end
                end
                default: begin
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    turbo_frame_ctrl_cw_serializer u_ser (
        .clk      (clk),
        .reset    (reset),
        .load     (ser_load),
        .codeword (bus.enc_out),
        .tx_ready (bus.tx_ready),
        .tx_valid (ser_valid),
        .tx_data  (ser_data),
        .done     (ser_done)
    );

    assign bus.in_ready   = in_ready_c;
    assign bus.enc_rst    = enc_rst_c;
    assign bus.enc_sel    = sel_q;
    assign bus.enc_data   = data_q;
    assign bus.tx_valid   = ser_valid;
    assign bus.tx_data    = ser_data;
    assign bus.busy       = busy_c;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_turbo_frame_ctrl.sv
// Bench for turbo_frame_ctrl: two instances (FRAME_LEN 1 and 2), one active at a time.
// Expected values come from a transaction-level model of frames, latencies and byte order.
// Randomised tx_ready stalls, codewords and cfg_sel changes on top of directed steps.
module tb_turbo_frame_ctrl;
    import turbo_frame_ctrl_pkg::*;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  cfg_sel = 2'd0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic [23:0] enc_out = 24'd0;
    logic        tx_ready = 1'b1;
    int          dut_sel = 0;

    int checks = 0;
    int errors = 0;

    // model state
    int         frame_pos = 0;
    logic [1:0] frame_sel = 2'd0;

    always #5 clk = ~clk;

    turbo_frame_ctrl_if if_a ();
    turbo_frame_ctrl_if if_b ();

    turbo_frame_ctrl #(.ENC_LATENCY(L), .FRAME_LEN(1)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
    turbo_frame_ctrl #(.ENC_LATENCY(L), .FRAME_LEN(2)) dut_b (.clk(clk), .reset(reset), .bus(if_b));

    assign if_a.cfg_sel  = cfg_sel;
    assign if_b.cfg_sel  = cfg_sel;
    assign if_a.in_data  = in_data;
    assign if_b.in_data  = in_data;
    assign if_a.enc_out  = enc_out;
    assign if_b.enc_out  = enc_out;
    assign if_a.tx_ready = tx_ready;
    assign if_b.tx_ready = tx_ready;
    assign if_a.in_valid = in_valid & (dut_sel == 0);
    assign if_b.in_valid = in_valid & (dut_sel == 1);

    logic       o_in_ready, o_enc_rst, o_tx_valid, o_busy, o_frame_done;
    logic [1:0] o_enc_sel;
    logic [7:0] o_enc_data, o_tx_data;

    assign o_in_ready   = (dut_sel == 1) ? if_b.in_ready   : if_a.in_ready;
    assign o_enc_rst    = (dut_sel == 1) ? if_b.enc_rst    : if_a.enc_rst;
    assign o_enc_sel    = (dut_sel == 1) ? if_b.enc_sel    : if_a.enc_sel;
    assign o_enc_data   = (dut_sel == 1) ? if_b.enc_data   : if_a.enc_data;
    assign o_tx_valid   = (dut_sel == 1) ? if_b.tx_valid   : if_a.tx_valid;
    assign o_tx_data    = (dut_sel == 1) ? if_b.tx_data    : if_a.tx_data;
    assign o_busy       = (dut_sel == 1) ? if_b.busy       : if_a.busy;
    assign o_frame_done = (dut_sel == 1) ? if_b.frame_done : if_a.frame_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"},   o_in_ready,   0);
        chk({tag, "_enc_rst"},    o_enc_rst,    0);
        chk({tag, "_enc_sel"},    o_enc_sel,    0);
        chk({tag, "_enc_data"},   o_enc_data,   0);
        chk({tag, "_tx_valid"},   o_tx_valid,   0);
        chk({tag, "_tx_data"},    o_tx_data,    0);
        chk({tag, "_busy"},       o_busy,       0);
        chk({tag, "_frame_done"}, o_frame_done, 0);
    endtask

    // One byte through the active instance: accept, hold window, 3 tx bytes, frame end.
    task automatic send_byte(input logic [7:0] data, input logic [23:0] cw, input logic [1:0] sel,
                             input int stall_b1, input bit hold, input logic [7:0] hold_dat,
                             input bit abort);
        int         c;
        int         fl;
        int         st;
        bit         first, lastf, ok, sent;
        logic [7:0] exp;
        fl    = (dut_sel == 1) ? 2 : 1;
        first = (frame_pos == 0);
        lastf = (frame_pos == fl - 1);
        in_data  = data;
        in_valid = 1'b1;
        cfg_sel  = sel;
        enc_out  = cw;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (o_in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
            chk("idle_frame_done", o_frame_done, 0);
        end
        if (!ok) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        step();
        if (first) frame_sel = sel;
        in_valid = hold;
        in_data  = hold ? hold_dat : 8'($urandom);
        c = 1;
        while (o_tx_valid !== 1'b1) begin
            if (c > 20) begin
                chk("tx_valid_timeout", 0, 1);
                return;
            end
            chk("wait_enc_rst",    o_enc_rst, (first && c == 1));
            chk("wait_in_ready",   o_in_ready, 0);
            chk("wait_enc_data",   o_enc_data, data);
            chk("wait_enc_sel",    o_enc_sel, frame_sel);
            chk("wait_busy",       o_busy, 1);
            chk("wait_frame_done", o_frame_done, 0);
            cfg_sel = 2'($urandom);
            step();
            c++;
        end
        chk("first_tx_latency", c, first ? L + 2 : L + 1);
        for (int b = 0; b < 3; b++) begin
            st   = (b == 1) ? stall_b1 : int'($urandom_range(0, 2));
            sent = 1'b0;
            exp  = cw[23 - 8*b -: 8];
            if (abort && b == 1) begin
                reset = 1'b1;
                #1;
                chk_all_zero("abort");
                step();
                chk_all_zero("abort_hold");
                reset    = 1'b0;
                tx_ready = 1'b1;
                in_valid = 1'b0;
                frame_pos = 0;
                step();
                chk("abort_in_ready", o_in_ready, 1);
                chk("abort_no_done",  o_frame_done, 0);
                return;
            end
            while (!sent) begin
                chk("tx_valid",      o_tx_valid, 1);
                chk("tx_data",       o_tx_data, exp);
                chk("tx_in_ready",   o_in_ready, 0);
                chk("tx_enc_rst",    o_enc_rst, 0);
                chk("tx_enc_sel",    o_enc_sel, frame_sel);
                chk("tx_frame_done", o_frame_done, 0);
                if (st > 0) begin
                    tx_ready = 1'b0;
                    st--;
                end else begin
                    tx_ready = 1'b1;
                    sent = 1'b1;
                end
                enc_out = 24'($urandom);
                cfg_sel = 2'($urandom);
                step();
            end
        end
        chk("end_frame_done", o_frame_done, lastf);
        chk("end_tx_valid",   o_tx_valid, 0);
        chk("end_in_ready",   o_in_ready, 1);
        chk("end_busy",       o_busy, !lastf);
        chk("end_enc_sel",    o_enc_sel, frame_sel);
        chk("end_enc_data",   o_enc_data, data);
        frame_pos = lastf ? 0 : frame_pos + 1;
    endtask

    initial begin
        logic [7:0] d, nd;
        bit         h;
        // reset state of both instances
        step();
        step();
        dut_sel = 0;
        #0 chk_all_zero("rst_a");
        dut_sel = 1;
        #0 chk_all_zero("rst_b");
        reset = 1'b0;
        step();
        chk("post_rst_in_ready", o_in_ready, 1);
        chk("post_rst_busy",     o_busy, 0);

        // FRAME_LEN=1: single-byte frame, then backpressure of 5 cycles on 0x34
        dut_sel = 0;
        send_byte(8'hA5, 24'h123456, 2'd2, 0, 1'b0, 8'h00, 1'b0);
        send_byte(8'h3C, 24'h123456, 2'd2, 5, 1'b0, 8'h00, 1'b0);

        // FRAME_LEN=2: two bytes, select latched once, next frame picks up 3
        dut_sel = 1;
        send_byte(8'h01, 24'hABCDEF, 2'd1, 0, 1'b0, 8'h00, 1'b0);
        send_byte(8'h02, 24'hABCDEF, 2'd3, 1, 1'b0, 8'h00, 1'b0);
        send_byte(8'h11, 24'h0F1E2D, 2'd3, 0, 1'b0, 8'h00, 1'b0);

        // upstream holding its byte through WAIT/SEND, accepted on IDLE then NEXT entry
        send_byte(8'h12, 24'h654321, 2'd0, 2, 1'b1, 8'h77, 1'b0);
        send_byte(8'h77, 24'h55AA33, 2'd2, 0, 1'b1, 8'h66, 1'b0);
        send_byte(8'h66, 24'hC3C3C3, 2'd0, 3, 1'b0, 8'h00, 1'b0);

        // reset after the first tx byte, then a clean frame
        send_byte(8'h21, 24'hFEDCBA, 2'd1, 0, 1'b0, 8'h00, 1'b1);
        send_byte(8'h22, 24'h13579B, 2'd2, 0, 1'b0, 8'h00, 1'b0);
        send_byte(8'h23, 24'h2468AC, 2'd0, 0, 1'b0, 8'h00, 1'b0);

        // randomised traffic across both instances
        d = 8'($urandom);
        for (int n = 0; n < 60; n++) begin
            if (frame_pos == 0) dut_sel = int'($urandom_range(0, 1));
            nd = 8'($urandom);
            h  = ($urandom_range(0, 3) == 0);
            send_byte(d, 24'($urandom), 2'($urandom), int'($urandom_range(0, 4)), h, nd, 1'b0);
            d = h ? nd : 8'($urandom);
        end
        in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
